// File: rtl/simon3264_pkg.sv
// ==== simon3264_pkg : shared SIMON32/64 constants and helpers | rev 1.0 ====
`default_nettype none

package simon3264_pkg;

  localparam int WORD_W         = 16;
  localparam int IDX_W          = 5;
  localparam int DEFAULT_ROUNDS = 32;

  localparam logic [WORD_W-1:0] C_CONST = 16'hFFFC;
  // Leftmost character of the z0 string is element 0, so it sits at bit 61.
  localparam logic [61:0] Z0_SEQ =
    62'b11111010001001010110000111001101111101000100101011000011100110;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ks_state_e;

  function automatic logic z0_bit(input logic [IDX_W-1:0] idx);
    logic [5:0] pos;
    pos = 6'd61 - {1'b0, idx};
    return Z0_SEQ[pos];
  endfunction

  function automatic word_t ror1(input word_t x);
    return {x[0], x[WORD_W-1:1]};
  endfunction

  function automatic word_t ror3(input word_t x);
    return {x[2:0], x[WORD_W-1:3]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/simon3264_ks_step.sv
// ==== simon3264_ks_step : one SIMON32/64 key-expansion step (combinational) | rev 1.0 ====
`default_nettype none

module simon3264_ks_step
  import simon3264_pkg::*;
(
  input  logic [WORD_W-1:0] w0,
  input  logic [WORD_W-1:0] w1,
  input  logic [WORD_W-1:0] w3,
  input  logic              z,
  output logic [WORD_W-1:0] knew
);

  logic [WORD_W-1:0] t;

  // C already folds in the bitwise NOT of w0 and the constant 3.
  always_comb begin
    t    = ror3(w3) ^ w1;
    knew = C_CONST ^ {{(WORD_W-1){1'b0}}, z} ^ w0 ^ t ^ ror1(t);
  end

endmodule

`default_nettype wire

// File: rtl/simon3264_key_schedule.sv
// ==== simon3264_key_schedule : streams SIMON32/64 round keys over valid/ready | rev 1.0 ====
`default_nettype none

module simon3264_key_schedule
  import simon3264_pkg::*;
#(
  parameter int ROUNDS = DEFAULT_ROUNDS
)
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [63:0]         key,
  output logic                busy,
  output logic                rk_valid,
  input  logic                rk_ready,
  output logic [WORD_W-1:0]   rk,
  output logic [IDX_W-1:0]    rk_idx,
  output logic                rk_last
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

  ks_state_e          state_q, state_d;
  logic [WORD_W-1:0]  w0_q, w1_q, w2_q, w3_q;
  logic [WORD_W-1:0]  w0_d, w1_d, w2_d, w3_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               last_q, last_d;

  logic [WORD_W-1:0]  knew;
  logic [IDX_W-1:0]   idx_inc;
  logic               handshake;

  simon3264_ks_step u_step (
    .w0   (w0_q),
    .w1   (w1_q),
    .w3   (w3_q),
    .z    (z0_bit(idx_q)),
    .knew (knew)
  );

  assign handshake = valid_q & rk_ready;
  assign idx_inc   = idx_q + IDX_W'(1);

  always_comb begin
    state_d = state_q;
    w0_d    = w0_q;
    w1_d    = w1_q;
    w2_d    = w2_q;
    w3_d    = w3_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    last_d  = last_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          w0_d    = key[15:0];
          w1_d    = key[31:16];
          w2_d    = key[47:32];
          w3_d    = key[63:48];
          idx_d   = '0;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          last_d  = 1'b0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (handshake) begin
          if (last_q) begin
            // Index and words are left as-is; nothing downstream looks at them while idle.
            valid_d = 1'b0;
            busy_d  = 1'b0;
            last_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            w0_d   = w1_q;
            w1_d   = w2_q;
            w2_d   = w3_q;
            w3_d   = knew;
            idx_d  = idx_inc;
            last_d = (idx_inc == LAST_IDX);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      w0_q    <= '0;
      w1_q    <= '0;
      w2_q    <= '0;
      w3_q    <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      w0_q    <= w0_d;
      w1_q    <= w1_d;
      w2_q    <= w2_d;
      w3_q    <= w3_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
    end
  end

  assign rk       = w0_q;
  assign rk_idx   = idx_q;
  assign rk_last  = last_q;
  assign rk_valid = valid_q;
  assign busy     = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_simon3264_key_schedule.sv
// ==== tb_simon3264_key_schedule : scoreboard bench for the SIMON32/64 key schedule | rev 1.0 ====
`default_nettype none

module tb_simon3264_key_schedule;

  localparam int ROUNDS_TB = 32;
  localparam logic [63:0] KEY_REF = 64'h1918_1110_0908_0100;

  typedef struct packed {
    logic [15:0] rk;
    logic [4:0]  idx;
    logic        last;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [63:0] key;
  logic        busy;
  logic        rk_valid;
  logic        rk_ready;
  logic [15:0] rk;
  logic [4:0]  rk_idx;
  logic        rk_last;

  logic        start5;
  logic [63:0] key5;
  logic        busy5;
  logic        valid5;
  logic        rdy5;
  logic [15:0] rk5;
  logic [4:0]  idx5;
  logic        last5;

  int   n_vec;
  int   n_err;
  exp_t q[$];
  exp_t e;

  simon3264_key_schedule #(.ROUNDS(ROUNDS_TB)) dut (
    .clk(clk), .rst(rst), .start(start), .key(key), .busy(busy),
    .rk_valid(rk_valid), .rk_ready(rk_ready), .rk(rk), .rk_idx(rk_idx), .rk_last(rk_last)
  );

  simon3264_key_schedule #(.ROUNDS(5)) dut5 (
    .clk(clk), .rst(rst), .start(start5), .key(key5), .busy(busy5),
    .rk_valid(valid5), .rk_ready(rdy5), .rk(rk5), .rk_idx(idx5), .rk_last(last5)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got running, need finished");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] rotr(input logic [15:0] x, input int n);
    return (x >> n) | (x << (16 - n));
  endfunction

  // Textbook SIMON32/64 expansion: k[i+4] = ~k[i] ^ tmp ^ ror1(tmp) ^ z0[i] ^ 3.
  task automatic push_keys(input logic [63:0] k_in, input int rounds);
    logic [15:0] k [0:31];
    logic [15:0] tmp;
    logic [61:0] z;
    exp_t        x;
    z = 62'b11111010001001010110000111001101111101000100101011000011100110;
    for (int i = 0; i < 4; i++) k[i] = k_in[16*i +: 16];
    for (int i = 0; i < rounds - 4; i++) begin
      tmp = rotr(k[i+3], 3) ^ k[i+1];
      tmp = tmp ^ rotr(tmp, 1);
      k[i+4] = ~k[i] ^ tmp ^ {15'd0, z[61-i]} ^ 16'd3;
    end
    for (int i = 0; i < rounds; i++) begin
      x.rk   = k[i];
      x.idx  = 5'(i);
      x.last = (i == rounds - 1);
      q.push_back(x);
    end
  endtask

  // Monitor for the main instance: handshake pops, valid/busy agreement, stall stability.
  logic        stall_prev = 1'b0;
  logic        rst_prev   = 1'b1;
  logic [15:0] rk_hold;
  logic [4:0]  idx_hold;
  logic        last_hold;

  always @(negedge clk) begin
    if (!rst && !rst_prev && stall_prev) begin
      n_vec++;
      if (!rk_valid || rk !== rk_hold || rk_idx !== idx_hold || rk_last !== last_hold) begin
        n_err++;
        $display("FAIL stall_hold: got v=%b rk=%h idx=%0d last=%b, need v=1 rk=%h idx=%0d last=%b",
                 rk_valid, rk, rk_idx, rk_last, rk_hold, idx_hold, last_hold);
      end
    end
    if (!rst) begin
      n_vec++;
      if (rk_valid !== (q.size() != 0) || busy !== (q.size() != 0)) begin
        n_err++;
        $display("FAIL valid_busy: got valid=%b busy=%b, need both %b",
                 rk_valid, busy, (q.size() != 0));
      end
      if (rk_valid === 1'b1 && rk_ready === 1'b1 && q.size() != 0) begin
        e = q.pop_front();
        n_vec++;
        if (rk !== e.rk || rk_idx !== e.idx || rk_last !== e.last) begin
          n_err++;
          $display("FAIL round_key: got rk=%h idx=%0d last=%b, need rk=%h idx=%0d last=%b",
                   rk, rk_idx, rk_last, e.rk, e.idx, e.last);
        end
      end
    end
    stall_prev = rk_valid && !rk_ready;
    rk_hold    = rk;
    idx_hold   = rk_idx;
    last_hold  = rk_last;
    rst_prev   = rst;
  end

  // Monitor for the ROUNDS=5 instance against the published first five keys.
  logic [15:0] exp5 [0:4] = '{16'h0100, 16'h0908, 16'h1110, 16'h1918, 16'h71C3};
  int cnt5 = 0;

  always @(negedge clk) begin
    if (!rst && valid5 === 1'b1) begin
      n_vec++;
      if (cnt5 > 4) begin
        n_err++;
        $display("FAIL r5_extra: got key %0d, need at most 5 keys", cnt5 + 1);
      end else if (rk5 !== exp5[cnt5] || idx5 !== 5'(cnt5) || last5 !== (cnt5 == 4)) begin
        n_err++;
        $display("FAIL r5_key: got rk=%h idx=%0d last=%b, need rk=%h idx=%0d last=%b",
                 rk5, idx5, last5, exp5[cnt5], cnt5, (cnt5 == 4));
      end
      cnt5++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] need);
    n_vec++;
    if (got !== need) begin
      n_err++;
      $display("FAIL %s: got %h, need %h", name, got, need);
    end
  endtask

  task automatic do_start(input logic [63:0] k);
    start = 1'b1;
    key   = k;
    tick();
    start = 1'b0;
    key   = {$urandom, $urandom};
    push_keys(k, ROUNDS_TB);
  endtask

  // mode 0: ready always high, 1: toggle 1/0, 2: random ready with stray start pulses
  task automatic run_until_idle(input int mode, input int budget, output int cycles);
    cycles = 0;
    while (q.size() != 0 || rk_valid) begin
      if (cycles >= budget) begin
        n_vec++;
        n_err++;
        $display("FAIL timeout: got %0d cycles still busy, need idle", cycles);
        q.delete();
        return;
      end
      case (mode)
        0:       rk_ready = 1'b1;
        1:       rk_ready = (cycles % 2 == 0);
        default: rk_ready = 1'($urandom_range(0, 1));
      endcase
      if (mode == 2 && rk_valid && $urandom_range(0, 7) == 0) begin
        start = 1'b1;
        key   = {$urandom, $urandom};
      end
      tick();
      start = 1'b0;
      cycles++;
    end
  endtask

  int cyc;
  logic [63:0] k2;

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1; start = 1'b0; key = '0; rk_ready = 1'b0;
    start5 = 1'b0; key5 = '0; rdy5 = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("reset_valid", 32'(rk_valid), 32'd0);
    check("reset_busy",  32'(busy), 32'd0);
    check("reset_rk",    32'(rk), 32'd0);
    check("reset_idx",   32'(rk_idx), 32'd0);
    check("reset_last",  32'(rk_last), 32'd0);
    tick();

    // Reference key, full-rate ready: one key per cycle.
    rk_ready = 1'b1;
    do_start(KEY_REF);
    check("first_rk", 32'(rk), 32'h0100);
    run_until_idle(0, 100, cyc);
    check("full_rate_cycles", cyc, ROUNDS_TB);
    @(negedge clk);
    check("busy_after_last", 32'(busy), 32'd0);
    tick();

    // Ready toggling: every other cycle stalls.
    rk_ready = 1'b1;
    do_start(KEY_REF);
    run_until_idle(1, 200, cyc);
    check("toggle_cycles", cyc + 1, 2 * ROUNDS_TB);
    tick();

    // Start with another key during RUN must be ignored.
    do_start(KEY_REF);
    for (int i = 0; i < 3; i++) tick();
    start = 1'b1;
    key   = 64'hDEAD_BEEF_CAFE_F00D;
    tick();
    start = 1'b0;
    run_until_idle(0, 100, cyc);
    tick();

    // Reset mid-sequence at index 10.
    do_start(KEY_REF);
    rk_ready = 1'b1;
    cyc = 0;
    while (rk_idx !== 5'd10 && cyc < 40) begin
      tick();
      cyc++;
    end
    check("reached_idx10", 32'(rk_idx), 32'd10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q.delete();
    @(negedge clk);
    check("mid_rst_valid", 32'(rk_valid), 32'd0);
    check("mid_rst_busy",  32'(busy), 32'd0);
    check("mid_rst_rk",    32'(rk), 32'd0);
    tick();
    do_start(KEY_REF);
    check("restart_rk",  32'(rk), 32'h0100);
    check("restart_idx", 32'(rk_idx), 32'd0);

    // Back-to-back: new start in the cycle right after the last handshake.
    run_until_idle(0, 100, cyc);
    k2 = 64'h0123_4567_89AB_CDEF;
    do_start(k2);
    check("b2b_valid", 32'(rk_valid), 32'd1);
    check("b2b_rk",    32'(rk), 32'(k2[15:0]));
    run_until_idle(0, 100, cyc);
    tick();

    // Randomized keys, random backpressure and stray start pulses.
    for (int n = 0; n < 6; n++) begin
      do_start({$urandom, $urandom});
      run_until_idle(2, 400, cyc);
      if ($urandom_range(0, 1) == 1) tick();
    end

    // ROUNDS=5 build.
    start5 = 1'b1;
    key5   = KEY_REF;
    tick();
    start5 = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("r5_count", cnt5, 32'd5);
    @(negedge clk);
    check("r5_idle_valid", 32'(valid5), 32'd0);
    check("r5_idle_busy",  32'(busy5), 32'd0);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
